// File: rtl/instr_mem_loader_pkg.sv
// Shared opcode, field-offset and FSM state definitions for the instruction memory loader.
package instr_mem_loader_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_END = 4'd4;

  localparam logic [1:0] F_OP   = 2'd0;
  localparam logic [1:0] F_DST  = 2'd1;
  localparam logic [1:0] F_SRC1 = 2'd2;
  localparam logic [1:0] F_SRC2 = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PAD,
    SEAL,
    ENDFILL,
    DONE
  } state_t;

endpackage

// File: rtl/instr_mem_loader_nibble_ram.sv
// DEPTH x DATA_W flop array: async clear, one synchronous write port, one combinational read port.
module nibble_ram #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DEPTH-1:0][DATA_W-1:0] mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem <= '0;
    else if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_mem_loader.sv
// Fills the 64x4 instruction nibble memory from a valid/ready stream, pads and seals the
// program with an END instruction, and serves the checker's combinational read port.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64,
  parameter int END_OP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              restart,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] send,
  output logic              prog_done,
  output logic              overflow,
  output logic [4:0]        instr_count
);

  // Last nibble before the reserved END slot; accepting it without an end truncates.
  localparam logic [ADDR_W-1:0] FULL_PTR = ADDR_W'(DEPTH - 5);
  localparam logic [DATA_W-1:0] END_NIB  = DATA_W'(END_OP);

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic              accept, slot_end, slot_op, in_end;
  logic              we;
  logic [DATA_W-1:0] wdata;

  assign accept   = in_valid && in_ready;
  assign slot_end = (wr_ptr[1:0] == F_SRC2);
  assign slot_op  = (wr_ptr[1:0] == F_OP);
  assign in_end   = slot_op && (in_data == END_NIB);

  always_comb begin
    we    = 1'b0;
    wdata = '0;
    case (state)
      IDLE, LOAD: begin
        we    = accept;
        wdata = in_data;
      end
      PAD, ENDFILL: we = 1'b1;
      SEAL: begin
        we    = 1'b1;
        wdata = slot_op ? END_NIB : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      instr_count <= '0;
      overflow    <= 1'b0;
      in_ready    <= 1'b1;
      prog_done   <= 1'b0;
    end else begin
      case (state)
        IDLE, LOAD: begin
          if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
            // An in-band END wins over in_last and is never counted.
            if (in_end) begin
              state    <= ENDFILL;
              in_ready <= 1'b0;
            end else begin
              if (slot_end) instr_count <= instr_count + 5'd1;
              if (in_last) begin
                state    <= slot_end ? SEAL : PAD;
                in_ready <= 1'b0;
              end else if (wr_ptr == FULL_PTR) begin
                state    <= SEAL;
                overflow <= 1'b1;
                in_ready <= 1'b0;
              end else begin
                state <= LOAD;
              end
            end
          end
        end
        PAD: begin
          wr_ptr <= wr_ptr + 1'b1;
          if (slot_end) begin
            instr_count <= instr_count + 5'd1;
            state       <= SEAL;
          end
        end
        SEAL, ENDFILL: begin
          wr_ptr <= wr_ptr + 1'b1;
          if (slot_end) begin
            state     <= DONE;
            prog_done <= 1'b1;
          end
        end
        DONE: begin
          if (restart) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            instr_count <= '0;
            overflow    <= 1'b0;
            in_ready    <= 1'b1;
            prog_done   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  nibble_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .waddr(wr_ptr),
    .wdata(wdata),
    .raddr(address),
    .rdata(send)
  );

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed + randomized bench for instr_mem_loader against a program-level memory image model.
module tb_instr_mem_loader;

  typedef logic [3:0] nib_q_t[$];
  localparam int DEPTH = 64;
  localparam logic [3:0] END_NIB = 4'd4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic       restart = 1'b0;
  logic [5:0] address = '0;
  logic [3:0] send;
  logic       prog_done;
  logic       overflow;
  logic [4:0] instr_count;

  int checks = 0;
  int failures = 0;
  logic [3:0] m [DEPTH];

  instr_mem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .restart    (restart),
    .address    (address),
    .send       (send),
    .prog_done  (prog_done),
    .overflow   (overflow),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected memory image, accepted-nibble count, instruction count and overflow of one load.
  task automatic model_load(input nib_q_t s, input int last_idx,
                            output int acc, output int cnt, output int ovf);
    int n;
    int end_at;
    bit saw_last;
    n = 0; end_at = -1; saw_last = 0; acc = 0;
    for (int k = 0; k < s.size() && n < DEPTH - 4; k++) begin
      m[n] = s[k];
      acc++;
      if (s[k] == END_NIB && n % 4 == 0) begin
        end_at = n;
        n++;
        break;
      end
      n++;
      if (k == last_idx) begin
        saw_last = 1;
        break;
      end
    end
    while (n % 4 != 0) begin
      m[n] = 4'd0;
      n++;
    end
    if (end_at >= 0) begin
      cnt = end_at / 4;
      ovf = 0;
    end else begin
      cnt = n / 4;
      ovf = saw_last ? 0 : 1;
      m[n] = END_NIB; m[n+1] = 4'd0; m[n+2] = 4'd0; m[n+3] = 4'd0;
    end
  endtask

  task automatic run_load(input nib_q_t s, input int last_idx, input bit rnd,
                          input int stop_after, output int acc);
    int cyc;
    bit v;
    cyc = 0; acc = 0;
    while (acc < s.size() && acc != stop_after && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (!in_ready) break;
      v = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_valid = v;
      in_data  = s[acc];
      in_last  = (acc == last_idx);
      @(posedge clk);
      #1;
      if (v) acc++;
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
    if (cyc >= 1000) begin
      checks++;
      failures++;
      $error("FAIL load_bound observed=%0d expected=%0d", acc, s.size());
    end
  endtask

  task automatic wait_done(input string tag);
    for (int c = 0; c < 20 && !prog_done; c++) @(negedge clk);
    @(negedge clk);
    chk({tag, "_done"}, prog_done, 1);
  endtask

  task automatic check_mem(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      address = 6'(a);
      #1;
      chk($sformatf("%s_mem%0d", tag, a), send, m[a]);
    end
  endtask

  task automatic verify_load(input string tag, input nib_q_t s, input int last_idx, input bit rnd);
    int acc, eacc, ecnt, eovf;
    model_load(s, last_idx, eacc, ecnt, eovf);
    run_load(s, last_idx, rnd, -1, acc);
    chk({tag, "_accepted"}, acc, eacc);
    wait_done(tag);
    chk({tag, "_ready"}, in_ready, 0);
    chk({tag, "_count"}, instr_count, ecnt);
    chk({tag, "_overflow"}, overflow, eovf);
    check_mem(tag);
  endtask

  task automatic do_restart(input string tag);
    @(negedge clk);
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
    @(negedge clk);
    chk({tag, "_rs_ready"}, in_ready, 1);
    chk({tag, "_rs_done"}, prog_done, 0);
    chk({tag, "_rs_count"}, instr_count, 0);
    chk({tag, "_rs_ovf"}, overflow, 0);
  endtask

  function automatic nib_q_t rand_prog(input int len, input bit allow_end);
    nib_q_t q;
    for (int i = 0; i < len; i++) begin
      if (i % 4 == 0)
        q.push_back((allow_end && $urandom_range(0, 7) == 0) ? END_NIB : 4'($urandom_range(0, 3)));
      else
        q.push_back(4'($urandom_range(0, 15)));
    end
    return q;
  endfunction

  initial begin
    nib_q_t s;
    int acc, eacc, ecnt, eovf, len;

    for (int a = 0; a < DEPTH; a++) m[a] = 4'd0;
    #12;
    chk("rst_ready", in_ready, 1);
    chk("rst_done", prog_done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_count", instr_count, 0);
    check_mem("rst");
    @(negedge clk);
    rst = 1'b0;

    // Seven instructions terminated by in_last on an aligned boundary.
    s = '{0,5,0,1, 2,6,2,5, 1,5,3,6, 3,6,5,4, 2,2,3,4, 1,6,5,4, 2,6,2,1};
    verify_load("seven", s, 27, 1'b0);
    address = 6'd28; #1; chk("seven_addr28", send, 4);
    address = 6'd7;  #1; chk("seven_addr7", send, 5);

    // Partial instruction padded; restart mid-pad must be ignored.
    do_restart("pad");
    s = '{0,5};
    model_load(s, 1, eacc, ecnt, eovf);
    run_load(s, 1, 1'b0, -1, acc);
    @(negedge clk);
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
    chk("pad_accepted", acc, eacc);
    wait_done("pad");
    chk("pad_count", instr_count, 1);
    chk("pad_overflow", overflow, 0);
    check_mem("pad");

    // In-band END at address 8; trailing nibbles must not be consumed.
    do_restart("inband");
    s = '{0,1,2,3, 1,4,5,6, 4,7,8,9, 0,1,1,1};
    verify_load("inband", s, 15, 1'b0);
    chk("inband_count2", instr_count, 2);
    @(negedge clk);
    in_valid = 1'b1; in_data = 4'd3;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    check_mem("inband_hold");

    // 70 nibbles with no terminator: truncated at 15 instructions.
    do_restart("ovf");
    s = rand_prog(70, 1'b0);
    verify_load("ovf", s, -1, 1'b1);
    chk("ovf_count15", instr_count, 15);
    address = 6'd60; #1; chk("ovf_addr60", send, 4);

    // Single-instruction reload over an existing image.
    do_restart("reload");
    s = '{3,6,5,4};
    verify_load("reload", s, 3, 1'b0);

    // Asynchronous reset in the middle of a load.
    do_restart("midrst");
    s = rand_prog(40, 1'b0);
    run_load(s, -1, 1'b1, 13, acc);
    chk("midrst_acc", acc, 13);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_ready", in_ready, 1);
    chk("midrst_done", prog_done, 0);
    chk("midrst_ovf", overflow, 0);
    chk("midrst_count", instr_count, 0);
    for (int a = 0; a < DEPTH; a++) m[a] = 4'd0;
    check_mem("midrst");
    @(negedge clk);
    rst = 1'b0;
    s = rand_prog(10, 1'b0);
    verify_load("postrst", s, 9, 1'b1);

    // Random programs with random length, occasional in-band END.
    for (int it = 0; it < 4; it++) begin
      do_restart($sformatf("rnd%0d", it));
      len = $urandom_range(1, 70);
      s = rand_prog(len, 1'b1);
      verify_load($sformatf("rnd%0d", it), s, len - 1, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
